// File: rtl/or_nway_frame_accum_if.sv
// Word-stream input and frame-result output bundle for or_nway_frame_accum.
interface or_nway_frame_accum_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_mask;
  logic               out_any;
  logic [COUNT_W-1:0] out_nz_cnt;
  logic [COUNT_W-1:0] out_len;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_mask, out_any, out_nz_cnt, out_len
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_mask, out_any, out_nz_cnt, out_len
  );
endinterface

// File: rtl/or_nway_frame_accum.sv
// Per-frame OR-mask / nonzero-count / length accumulator with a one-entry
// result register; valid/ready on both sides.
module or_nway_frame_accum #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 8
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  clear,
  or_nway_frame_accum_if.slave bus
);

  localparam int unsigned Levels = $clog2(WIDTH);
  localparam int unsigned Leaves = 1 << Levels;

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   acc_mask_q;
  logic [COUNT_W-1:0] acc_nz_q;
  logic [COUNT_W-1:0] acc_len_q;

  logic [Leaves-1:0]  pad;
  logic               word_nz;
  logic               fire;
  logic               frame_done;
  logic [WIDTH-1:0]   nxt_mask;
  logic [COUNT_W-1:0] nxt_nz;
  logic [COUNT_W-1:0] nxt_len;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] x);
    return (x == {COUNT_W{1'b1}}) ? x : x + COUNT_W'(1);
  endfunction

  // Zero-pad the word to a power of two so every tree level halves cleanly.
  always_comb begin
    pad = '0;
    pad[WIDTH-1:0] = bus.in_data;
  end

  for (genvar l = 0; l <= Levels; l++) begin : g_lvl
    logic [(Leaves >> l)-1:0] node;
    if (l == 0) begin : g_leaf
      assign node = pad;
    end else begin : g_or
      for (genvar n = 0; n < (Leaves >> l); n++) begin : g_node
        assign node[n] = g_lvl[l-1].node[2*n] | g_lvl[l-1].node[2*n+1];
      end
    end
  end

  assign word_nz = g_lvl[Levels].node[0];

  assign bus.out_valid = (state_q == StHold);
  assign bus.in_ready  = !bus.out_valid || bus.out_ready;

  assign fire       = bus.in_valid && bus.in_ready;
  assign frame_done = fire && bus.in_last && !clear;
  assign nxt_mask   = acc_mask_q | bus.in_data;
  assign nxt_nz     = word_nz ? sat_inc(acc_nz_q) : acc_nz_q;
  assign nxt_len    = sat_inc(acc_len_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StAccum;
      acc_mask_q     <= '0;
      acc_nz_q       <= '0;
      acc_len_q      <= '0;
      bus.out_mask   <= '0;
      bus.out_any    <= 1'b0;
      bus.out_nz_cnt <= '0;
      bus.out_len    <= '0;
    end else begin
      // clear drops the open frame, including an accepted last beat.
      if (clear) begin
        acc_mask_q <= '0;
        acc_nz_q   <= '0;
        acc_len_q  <= '0;
      end else if (fire) begin
        if (bus.in_last) begin
          acc_mask_q     <= '0;
          acc_nz_q       <= '0;
          acc_len_q      <= '0;
          bus.out_mask   <= nxt_mask;
          bus.out_any    <= |nxt_mask;
          bus.out_nz_cnt <= nxt_nz;
          bus.out_len    <= nxt_len;
        end else begin
          acc_mask_q <= nxt_mask;
          acc_nz_q   <= nxt_nz;
          acc_len_q  <= nxt_len;
        end
      end

      unique case (state_q)
        StAccum: if (frame_done) state_q <= StHold;
        StHold:  if (bus.out_ready && !frame_done) state_q <= StAccum;
        default: state_q <= StAccum;
      endcase
    end
  end

endmodule
